// File: rtl/alu_result_sel_pipe_if.sv
// Handshake bundle between the ALU function units, the result selector and
// the execute/writeback stage.
interface alu_result_sel_pipe_if #(
  parameter int N    = 4,
  parameter int CH   = 7,
  parameter int ERRW = 8
);
  localparam int SELW = $clog2(CH);

  logic              in_valid;
  logic              in_ready;
  logic [CH*N-1:0]   results;
  logic [SELW-1:0]   selec_alu;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      result;
  logic              flag_z;
  logic              flag_n;
  logic              sel_err;
  logic [ERRW-1:0]   err_count;

  modport master (
    output in_valid, results, selec_alu, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, sel_err, err_count
  );

  modport slave (
    input  in_valid, results, selec_alu, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, sel_err, err_count
  );
endinterface

// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result selector: picks one of CH channel results, derives
// zero/negative flags, flags illegal selects and counts them (saturating).
module alu_result_sel_pipe #(
  parameter int N    = 4,
  parameter int CH   = 7,
  parameter int ERRW = 8
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_sel_pipe_if.slave bus
);
  localparam int SELW = $clog2(CH);

  logic            out_valid_q;
  logic [N-1:0]    result_q;
  logic            flag_z_q;
  logic            flag_n_q;
  logic            sel_err_q;
  logic [ERRW-1:0] err_q;

  logic            accept;
  logic            legal;
  logic [N-1:0]    pick;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign legal        = (32'(bus.selec_alu) < 32'(CH));

  // Only legal codes match a channel, so illegal selects fall through to zero.
  always_comb begin
    pick = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (bus.selec_alu == SELW'(k)) pick = bus.results[k*N +: N];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      sel_err_q   <= 1'b0;
      err_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= pick;
      flag_z_q    <= (pick == '0);
      flag_n_q    <= pick[N-1];
      sel_err_q   <= !legal;
      if (!legal && (err_q != '1)) err_q <= err_q + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Scoreboard bench for alu_result_sel_pipe: a default-width instance and an
// ERRW=2 instance for counter saturation.
module tb_alu_result_sel_pipe;
  typedef struct {
    logic [3:0] r;
    logic       z;
    logic       n;
    logic       e;
    logic [7:0] c;
  } pkt_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   n_checks = 0;
  int   n_fail   = 0;
  pkt_t q0[$];
  pkt_t q1[$];

  always #5 clk = ~clk;

  alu_result_sel_pipe_if #(.N(4), .CH(7), .ERRW(8)) bus0 ();
  alu_result_sel_pipe_if #(.N(4), .CH(7), .ERRW(2)) bus1 ();

  alu_result_sel_pipe #(.N(4), .CH(7), .ERRW(8)) dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (bus0)
  );

  alu_result_sel_pipe #(.N(4), .CH(7), .ERRW(2)) dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (bus1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_pkt(input string tag, input pkt_t p, input int r, input int z,
                         input int n, input int e, input int c);
    chk({tag, "_result"},    r, int'(p.r));
    chk({tag, "_flag_z"},    z, int'(p.z));
    chk({tag, "_flag_n"},    n, int'(p.n));
    chk({tag, "_sel_err"},   e, int'(p.e));
    chk({tag, "_err_count"}, c, int'(p.c));
  endtask

  // Monitors: one scoreboard pop per drained output transaction.
  always @(negedge clk) begin
    pkt_t p;
    if (!rst0 && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mon0_unexpected: got output %0d expected no transaction", bus0.result);
      end else begin
        p = q0.pop_front();
        cmp_pkt("mon0", p, int'(bus0.result), int'(bus0.flag_z), int'(bus0.flag_n),
                int'(bus0.sel_err), int'(bus0.err_count));
      end
    end
  end

  always @(negedge clk) begin
    pkt_t p;
    if (!rst1 && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mon1_unexpected: got output %0d expected no transaction", bus1.result);
      end else begin
        p = q1.pop_front();
        cmp_pkt("mon1", p, int'(bus1.result), int'(bus1.flag_z), int'(bus1.flag_n),
                int'(bus1.sel_err), int'(bus1.err_count));
      end
    end
  end

  // Offers one transaction, waits (bounded) for in_ready, pushes the expectation.
  task automatic send(input int id, input logic [2:0] sel, input logic [27:0] res,
                      input logic [3:0] r, input logic z, input logic n,
                      input logic e, input logic [7:0] c);
    pkt_t p;
    int   w;
    logic rdy;
    p = '{r: r, z: z, n: n, e: e, c: c};
    if (id == 0) begin
      bus0.in_valid = 1'b1; bus0.selec_alu = sel; bus0.results = res;
    end else begin
      bus1.in_valid = 1'b1; bus1.selec_alu = sel; bus1.results = res;
    end
    w = 0;
    @(negedge clk);
    rdy = (id == 0) ? bus0.in_ready : bus1.in_ready;
    while (!rdy && w < 50) begin
      @(negedge clk);
      rdy = (id == 0) ? bus0.in_ready : bus1.in_ready;
      w++;
    end
    if (!rdy) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else if (id == 0) q0.push_back(p);
    else q1.push_back(p);
    @(posedge clk); #1;
    if (id == 0) begin
      bus0.in_valid = 1'b0;
      chk("out_valid_after_accept0", int'(bus0.out_valid), 1);
    end else begin
      bus1.in_valid = 1'b0;
      chk("out_valid_after_accept1", int'(bus1.out_valid), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sat_tab [5];
    sat_tab = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

    rst0 = 1'b1; rst1 = 1'b1;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.results = '0; bus0.selec_alu = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.results = '0; bus1.selec_alu = '0;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;

    chk("rst_out_valid", int'(bus0.out_valid), 0);
    chk("rst_result",    int'(bus0.result), 0);
    chk("rst_flag_z",    int'(bus0.flag_z), 0);
    chk("rst_flag_n",    int'(bus0.flag_n), 0);
    chk("rst_sel_err",   int'(bus0.sel_err), 0);
    chk("rst_err_count", int'(bus0.err_count), 0);
    chk("rst_in_ready",  int'(bus0.in_ready), 1);

    // Legal pass, back-to-back: channel k holds k+1.
    for (int k = 0; k < 7; k++)
      send(0, 3'(k), 28'h7654321, 4'(k + 1), 1'b0, 1'b0, 1'b0, 8'd0);

    // Flags: ch2 = 0, ch4 = 4'b1001.
    send(0, 3'd2, 28'h7694021, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    send(0, 3'd4, 28'h7694021, 4'd9, 1'b0, 1'b1, 1'b0, 8'd0);

    // Illegal select, then the same select without in_valid.
    send(0, 3'd7, 28'h7654321, 4'd0, 1'b1, 1'b0, 1'b1, 8'd1);
    bus0.selec_alu = 3'd7;
    repeat (3) @(posedge clk);
    #1 chk("idle_illegal_err_count", int'(bus0.err_count), 1);

    // Backpressure: A captured, then three stalled cycles with changing inputs.
    bus0.out_ready = 1'b0;
    send(0, 3'd3, 28'h7654321, 4'd4, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) begin
      bus0.in_valid  = 1'b1;
      bus0.selec_alu = (i == 1) ? 3'd7 : 3'(i);
      bus0.results   = 28'h0ABCDEF ^ 28'(i);
      @(negedge clk);
      chk("stall_in_ready", int'(bus0.in_ready), 0);
      chk("stall_result",   int'(bus0.result), 4);
      @(posedge clk); #1;
      chk("stall_err_count", int'(bus0.err_count), 1);
    end
    bus0.out_ready = 1'b1;
    send(0, 3'd5, 28'h7654321, 4'd6, 1'b0, 1'b0, 1'b0, 8'd1);
    @(posedge clk); #1;

    // Reset mid-stall with err_count at 2.
    bus0.out_ready = 1'b0;
    send(0, 3'd7, 28'h7654321, 4'd0, 1'b1, 1'b0, 1'b1, 8'd2);
    @(posedge clk); #1;
    chk("pre_reset_err_count", int'(bus0.err_count), 2);
    rst0 = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    rst0 = 1'b0;
    chk("midrst_out_valid", int'(bus0.out_valid), 0);
    chk("midrst_result",    int'(bus0.result), 0);
    chk("midrst_err_count", int'(bus0.err_count), 0);
    chk("midrst_in_ready",  int'(bus0.in_ready), 1);
    bus0.out_ready = 1'b1;

    // Saturation on the ERRW=2 instance.
    for (int i = 0; i < 5; i++)
      send(1, 3'd7, 28'h1234567, 4'd0, 1'b1, 1'b0, 1'b1, sat_tab[i]);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
Parametrised, registered successor to the combinational ALU result selector. It picks one of CH packed ALU unit results by `selec_alu` and registers it in a single-entry output stage with a valid/ready handshake. It also produces zero/negative flags and flags illegal select codes, with a saturating error counter. It sits between the ALU function units and the execute/writeback pipeline register, so downstream stalls backpressure the ALU.

Parameters:
- N, 4, data width of each ALU result and of the output.
- CH, 7, number of result channels (legal range 2..64).
- SELW, $clog2(CH) (derived, not overridden), select width; codes CH..2^SELW-1 are illegal.
- ERRW, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  `results`/`selec_alu` are valid this cycle
- in_ready  output  1  block accepts the input this cycle
- results  input  CH*N  packed channel results; channel k = bits [k*N+N-1 : k*N]
- selec_alu  input  SELW  channel select
- out_valid  output  1  output register holds a transaction
- out_ready  input  1  consumer takes the output this cycle
- result  output  N  registered selected value
- flag_z  output  1  registered: selected value == 0
- flag_n  output  1  registered: selected value bit N-1
- sel_err  output  1  registered: this transaction used an illegal select
- err_count  output  ERRW  illegal-select transactions since reset, saturating

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out_valid=0, result=0, flag_z=0, flag_n=0, sel_err=0, err_count=0.
  - in_ready=1 in the cycle after reset deasserts.
- in_ready = !out_valid || out_ready. This is combinational and may depend on out_ready; there is no combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept at edge t, the following hold from t+1:
  - result, flag_z, flag_n, sel_err reflect the captured inputs.
  - out_valid=1.
  - Latency is 1 cycle.
- Legal select (selec_alu < CH): result = channel[selec_alu]; flag_z = (result==0); flag_n = result[N-1]; sel_err=0.
- Illegal select (selec_alu >= CH, e.g. 3'b111 for CH=7):
  - result=0, flag_z=1, flag_n=0, sel_err=1.
  - err_count increments by 1 unless it is already 2^ERRW-1, where it holds.
  - Output is never X/Z.
- Drain without new accept (out_valid && out_ready && !(in_valid && in_ready)): out_valid becomes 0 next cycle. result and flags hold their last values.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new transaction replaces the old one in the same edge and out_valid stays 1. Full throughput of 1 transaction per cycle.
- Stall (out_valid && !out_ready):
  - in_ready=0.
  - result, flags and sel_err hold stable.
  - Inputs are ignored and err_count does not change.
- in_valid=0: no state change except a drain.
- Reset mid-operation: a pending output is discarded, with out_valid=0 and err_count=0 on the next cycle regardless of other inputs. Reset has priority over accept and drain.
- Only accepted transactions affect err_count; an illegal selec_alu with in_valid=0 or in_ready=0 is ignored.

Test Plan:
1. Reset then legal pass, with N=4, CH=7, out_ready=1; results channels 0..6 = 1,2,3,4,5,6,7; send selec_alu=0..6 back-to-back.
   - Required: out_valid rises 1 cycle after the first accept.
   - Required: result sequence is 1..7, one per cycle; flag_z=0; sel_err=0; err_count=0.
2. Flag check: channel 2 = 4'b0000 selected -> flag_z=1, flag_n=0. Channel 4 = 4'b1001 selected -> flag_z=0, flag_n=1.
3. Illegal select: selec_alu=3'b111 accepted -> result=0, flag_z=1, sel_err=1, err_count=1.
   - Same select with in_valid=0 -> err_count stays 1.
4. Backpressure: out_ready=0 for 3 cycles with in_valid=1 and changing inputs.
   - Required: in_ready=0; result holds the first value.
   - Required: on the cycle out_ready=1, the next input is accepted in the same edge and out_valid stays 1.
5. Saturation: with ERRW=2, send 5 illegal transactions -> err_count reads 1,2,3,3,3.
6. Reset mid-stall: out_valid=1, out_ready=0, err_count=2; assert reset one cycle.
   - Required next cycle: out_valid=0, result=0, err_count=0, in_ready=1.
